// File: rtl/alu_issue_scheduler_if.sv
// Bus bundle between the ALU issue scheduler and its environment: dispatch input,
// CDB snoop, combinational ALU connection and registered CDB result broadcast.
interface alu_issue_scheduler_if #(
  parameter int ROB_IDX_LEN = 4,
  parameter int DATA_LEN    = 32,
  parameter int OPENUM_LEN  = 6
);
  logic                   rdy;
  logic                   flush;

  logic                   disp_valid;
  logic [OPENUM_LEN-1:0]  disp_openum;
  logic [DATA_LEN-1:0]    disp_v1;
  logic [DATA_LEN-1:0]    disp_v2;
  logic [ROB_IDX_LEN-1:0] disp_q1;
  logic [ROB_IDX_LEN-1:0] disp_q2;
  logic                   disp_p1;
  logic                   disp_p2;
  logic [ROB_IDX_LEN-1:0] disp_rob_tag;
  logic                   full;

  logic                   cdb_in_valid;
  logic [ROB_IDX_LEN-1:0] cdb_in_tag;
  logic [DATA_LEN-1:0]    cdb_in_value;

  logic [OPENUM_LEN-1:0]  alu_openum;
  logic [DATA_LEN-1:0]    alu_op1;
  logic [DATA_LEN-1:0]    alu_op2;
  logic [DATA_LEN-1:0]    alu_result;

  logic                   cdb_out_valid;
  logic [ROB_IDX_LEN-1:0] cdb_out_tag;
  logic [DATA_LEN-1:0]    cdb_out_value;

  modport slave (
    input  rdy, flush,
    input  disp_valid, disp_openum, disp_v1, disp_v2, disp_q1, disp_q2,
    input  disp_p1, disp_p2, disp_rob_tag,
    output full,
    input  cdb_in_valid, cdb_in_tag, cdb_in_value,
    output alu_openum, alu_op1, alu_op2,
    input  alu_result,
    output cdb_out_valid, cdb_out_tag, cdb_out_value
  );

  modport master (
    output rdy, flush,
    output disp_valid, disp_openum, disp_v1, disp_v2, disp_q1, disp_q2,
    output disp_p1, disp_p2, disp_rob_tag,
    input  full,
    output cdb_in_valid, cdb_in_tag, cdb_in_value,
    input  alu_openum, alu_op1, alu_op2,
    output alu_result,
    input  cdb_out_valid, cdb_out_tag, cdb_out_value
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Reservation station for the single ALU: holds dispatched ops, wakes operands from the
// CDB, issues the lowest-index ready entry each cycle and registers the result for broadcast.
module alu_issue_scheduler #(
  parameter int RS_SIZE     = 16,
  parameter int RS_IDX_LEN  = 4,
  parameter int ROB_IDX_LEN = 4,
  parameter int DATA_LEN    = 32,
  parameter int OPENUM_LEN  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_issue_scheduler_if.slave    bus
);

  typedef struct packed {
    logic [OPENUM_LEN-1:0]  openum;
    logic [DATA_LEN-1:0]    v1;
    logic [DATA_LEN-1:0]    v2;
    logic [ROB_IDX_LEN-1:0] q1;
    logic [ROB_IDX_LEN-1:0] q2;
    logic                   p1;
    logic                   p2;
    logic [ROB_IDX_LEN-1:0] rob_tag;
  } entry_t;

  logic [RS_SIZE-1:0]    valid_q;
  entry_t                rs_q [RS_SIZE];

  logic [RS_SIZE-1:0]    ready_vec;
  logic [RS_IDX_LEN-1:0] free_idx;
  logic [RS_IDX_LEN-1:0] issue_idx;
  logic                  issue_found;
  logic                  issue_en;
  logic                  disp_en;
  entry_t                disp_entry;

  assign bus.full = &valid_q;

  // Priority encoders: descending loops leave the lowest matching index in place.
  // NOTE: every always_comb output is assigned a default first so no latch is inferred.
  always_comb begin
    ready_vec   = '0;
    free_idx    = '0;
    issue_idx   = '0;
    issue_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ready_vec[i] = valid_q[i] & ~rs_q[i].p1 & ~rs_q[i].p2;
      if (!valid_q[i]) begin
        free_idx = RS_IDX_LEN'(i);
      end
      if (ready_vec[i]) begin
        issue_idx   = RS_IDX_LEN'(i);
        issue_found = 1'b1;
      end
    end
  end

  // Nothing leaves the station on a flush or frozen cycle, so the ALU sees zeros then.
  assign issue_en = issue_found & bus.rdy & ~bus.flush;
  assign disp_en  = bus.disp_valid & ~bus.full & bus.rdy & ~bus.flush;

  always_comb begin
    bus.alu_openum = '0;
    bus.alu_op1    = '0;
    bus.alu_op2    = '0;
    if (issue_en) begin
      bus.alu_openum = rs_q[issue_idx].openum;
      bus.alu_op1    = rs_q[issue_idx].v1;
      bus.alu_op2    = rs_q[issue_idx].v2;
    end
  end

  // A same-cycle CDB broadcast of a dispatched operand's producer is captured on entry.
  always_comb begin
    disp_entry.openum  = bus.disp_openum;
    disp_entry.v1      = bus.disp_v1;
    disp_entry.v2      = bus.disp_v2;
    disp_entry.q1      = bus.disp_q1;
    disp_entry.q2      = bus.disp_q2;
    disp_entry.p1      = bus.disp_p1;
    disp_entry.p2      = bus.disp_p2;
    disp_entry.rob_tag = bus.disp_rob_tag;
    if (bus.disp_p1 && bus.cdb_in_valid && bus.cdb_in_tag == bus.disp_q1) begin
      disp_entry.v1 = bus.cdb_in_value;
      disp_entry.p1 = 1'b0;
    end
    if (bus.disp_p2 && bus.cdb_in_valid && bus.cdb_in_tag == bus.disp_q2) begin
      disp_entry.v2 = bus.cdb_in_value;
      disp_entry.p2 = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      bus.cdb_out_valid <= 1'b0;
      bus.cdb_out_tag   <= '0;
      bus.cdb_out_value <= '0;
    end else if (bus.flush) begin
      valid_q           <= '0;
      bus.cdb_out_valid <= 1'b0;
    end else if (bus.rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (disp_en && free_idx == RS_IDX_LEN'(i)) begin
          valid_q[i] <= 1'b1;
        end else if (issue_en && issue_idx == RS_IDX_LEN'(i)) begin
          valid_q[i] <= 1'b0;
        end
      end
      bus.cdb_out_valid <= issue_en;
      if (issue_en) begin
        bus.cdb_out_tag   <= rs_q[issue_idx].rob_tag;
        bus.cdb_out_value <= bus.alu_result;
      end
    end
  end

  // NOTE: the entry payload is storage, not control; only valid_q needs reset because
  // an invalid entry's fields are never observed.
  always_ff @(posedge clk) begin
    if (bus.rdy && !bus.flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (disp_en && free_idx == RS_IDX_LEN'(i)) begin
          rs_q[i] <= disp_entry;
        end else if (bus.cdb_in_valid) begin
          if (rs_q[i].p1 && rs_q[i].q1 == bus.cdb_in_tag) begin
            rs_q[i].v1 <= bus.cdb_in_value;
            rs_q[i].p1 <= 1'b0;
          end
          if (rs_q[i].p2 && rs_q[i].q2 == bus.cdb_in_tag) begin
            rs_q[i].v2 <= bus.cdb_in_value;
            rs_q[i].p2 <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Scoreboard bench for alu_issue_scheduler: a slot-array reference model predicts ALU drive,
// full and each broadcast (tag, value, cycle); an independent monitor checks the CDB output.
module tb_alu_issue_scheduler;

  logic clk;
  logic rst_n;

  alu_issue_scheduler_if #(.ROB_IDX_LEN(4), .DATA_LEN(32), .OPENUM_LEN(6)) bus ();

  alu_issue_scheduler #(
    .RS_SIZE(16), .RS_IDX_LEN(4), .ROB_IDX_LEN(4), .DATA_LEN(32), .OPENUM_LEN(6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Bench ALU: result = op1 ^ op2.
  assign bus.alu_result = bus.alu_op1 ^ bus.alu_op2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit edge_active = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: 16 slots, lowest free slot takes dispatch, lowest ready slot issues.
  typedef struct {
    bit        v;
    bit [5:0]  op;
    bit [31:0] v1, v2;
    bit [3:0]  q1, q2;
    bit        p1, p2;
    bit [3:0]  tag;
  } slot_t;

  typedef struct {
    bit [3:0]  tag;
    bit [31:0] value;
    int        due;
  } exp_t;

  slot_t m [16];
  exp_t  exp_q [$];

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m[i].v = 1'b0;
  endtask

  task automatic model_step();
    bit act, full_m;
    int iss, fre;
    exp_t e;
    act    = bus.rdy && !bus.flush;
    full_m = 1'b1;
    fre    = -1;
    iss    = -1;
    for (int i = 0; i < 16; i++) begin
      if (!m[i].v) begin
        full_m = 1'b0;
        if (fre < 0) fre = i;
      end
      if (iss < 0 && m[i].v && !m[i].p1 && !m[i].p2) iss = i;
    end
    check("full", 64'(bus.full), 64'(full_m));
    if (act && iss >= 0) begin
      check("alu_openum", 64'(bus.alu_openum), 64'(m[iss].op));
      check("alu_op1", 64'(bus.alu_op1), 64'(m[iss].v1));
      check("alu_op2", 64'(bus.alu_op2), 64'(m[iss].v2));
    end else begin
      check("alu_openum_idle", 64'(bus.alu_openum), 64'd0);
      check("alu_op1_idle", 64'(bus.alu_op1), 64'd0);
    end
    edge_active = act;
    if (bus.flush) begin
      model_clear();
    end else if (act) begin
      if (iss >= 0) begin
        e.tag   = m[iss].tag;
        e.value = m[iss].v1 ^ m[iss].v2;
        e.due   = cyc + 1;
        exp_q.push_back(e);
        m[iss].v = 1'b0;
      end
      if (bus.cdb_in_valid) begin
        for (int i = 0; i < 16; i++) begin
          if (m[i].v && m[i].p1 && m[i].q1 == bus.cdb_in_tag) begin
            m[i].v1 = bus.cdb_in_value; m[i].p1 = 1'b0;
          end
          if (m[i].v && m[i].p2 && m[i].q2 == bus.cdb_in_tag) begin
            m[i].v2 = bus.cdb_in_value; m[i].p2 = 1'b0;
          end
        end
      end
      if (bus.disp_valid && !full_m) begin
        m[fre].v   = 1'b1;
        m[fre].op  = bus.disp_openum;
        m[fre].v1  = bus.disp_v1;
        m[fre].v2  = bus.disp_v2;
        m[fre].q1  = bus.disp_q1;
        m[fre].q2  = bus.disp_q2;
        m[fre].p1  = bus.disp_p1;
        m[fre].p2  = bus.disp_p2;
        m[fre].tag = bus.disp_rob_tag;
        if (bus.disp_p1 && bus.cdb_in_valid && bus.cdb_in_tag == bus.disp_q1) begin
          m[fre].v1 = bus.cdb_in_value; m[fre].p1 = 1'b0;
        end
        if (bus.disp_p2 && bus.cdb_in_valid && bus.cdb_in_tag == bus.disp_q2) begin
          m[fre].v2 = bus.cdb_in_value; m[fre].p2 = 1'b0;
        end
      end
    end
  endtask

  // Monitor: every fresh broadcast must match the oldest prediction in the cycle it was due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.cdb_out_valid && edge_active) begin
        if (exp_q.size() == 0) begin
          check("cdb_out_unexpected", 64'(bus.cdb_out_tag), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("cdb_out_tag", 64'(bus.cdb_out_tag), 64'(e.tag));
          check("cdb_out_value", 64'(bus.cdb_out_value), 64'(e.value));
          check("cdb_out_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("cdb_out_missing", 64'(bus.cdb_out_valid), 64'd1);
      end
    end
  end

  task automatic clr_in();
    bus.flush        = 1'b0;
    bus.disp_valid   = 1'b0;
    bus.disp_openum  = '0;
    bus.disp_v1      = '0;
    bus.disp_v2      = '0;
    bus.disp_q1      = '0;
    bus.disp_q2      = '0;
    bus.disp_p1      = 1'b0;
    bus.disp_p2      = 1'b0;
    bus.disp_rob_tag = '0;
    bus.cdb_in_valid = 1'b0;
    bus.cdb_in_tag   = '0;
    bus.cdb_in_value = '0;
  endtask

  task automatic set_disp(input bit [5:0] op, input bit [31:0] v1, input bit [31:0] v2,
                          input bit [3:0] q1, input bit [3:0] q2, input bit p1, input bit p2,
                          input bit [3:0] tag);
    bus.disp_valid   = 1'b1;
    bus.disp_openum  = op;
    bus.disp_v1      = v1;
    bus.disp_v2      = v2;
    bus.disp_q1      = q1;
    bus.disp_q2      = q2;
    bus.disp_p1      = p1;
    bus.disp_p2      = p2;
    bus.disp_rob_tag = tag;
  endtask

  task automatic set_cdb(input bit [3:0] tag, input bit [31:0] value);
    bus.cdb_in_valid = 1'b1;
    bus.cdb_in_tag   = tag;
    bus.cdb_in_value = value;
  endtask

  // One clock: model predicts the coming edge, then inputs return to idle.
  task automatic tick();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
    clr_in();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    edge_active = 1'b0;
    #1;
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_cdb_out_valid", 64'(bus.cdb_out_valid), 64'd0);
    check("rst_alu_openum", 64'(bus.alu_openum), 64'd0);
    check("rst_sb_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    model_clear();
    clr_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    bus.rdy = 1'b1;
    clr_in();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("init_full", 64'(bus.full), 64'd0);
    check("init_cdb_out_valid", 64'(bus.cdb_out_valid), 64'd0);
    check("init_cdb_out_tag", 64'(bus.cdb_out_tag), 64'd0);
    check("init_alu_openum", 64'(bus.alu_openum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ready op: result 1 ^ FFFFFFFF on the CDB two cycles after dispatch.
    set_disp(6'd22, 32'h1, 32'hFFFF_FFFF, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3);
    tick();
    idle(4);

    // Operand 1 woken by a later CDB broadcast.
    set_disp(6'd5, 32'h1234, 32'h0, 4'd5, 4'd0, 1'b1, 1'b0, 4'd4);
    tick();
    idle(2);
    set_cdb(4'd5, 32'h10);
    tick();
    idle(4);

    // Operand 2 forwarded from the CDB in the dispatch cycle.
    set_disp(6'd7, 32'h3, 32'h0, 4'd0, 4'd7, 1'b0, 1'b1, 4'd6);
    set_cdb(4'd7, 32'd9);
    tick();
    idle(4);

    // Fill all 16 entries, drop the 17th, then release them in index order.
    for (int i = 0; i < 16; i++) begin
      set_disp(6'(i + 1), 32'(i), 32'(i * 3), 4'd2, 4'd0, 1'b1, 1'b0, 4'(i));
      tick();
    end
    check("full_after_16", 64'(bus.full), 64'd1);
    set_disp(6'd63, 32'hBAD, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd15);
    tick();
    check("full_after_drop", 64'(bus.full), 64'd1);
    set_cdb(4'd2, 32'hA5A5_0000);
    tick();
    idle(20);

    // Flush with 8 pending entries while a result is on the CDB.
    for (int i = 0; i < 8; i++) begin
      set_disp(6'd9, 32'(i), 32'h0, 4'd9, 4'd0, 1'b1, 1'b0, 4'(i));
      tick();
    end
    set_disp(6'd10, 32'h55, 32'hAA, 4'd0, 4'd0, 1'b0, 1'b0, 4'd8);
    tick();
    tick();
    check("pre_flush_cdb_out_valid", 64'(bus.cdb_out_valid), 64'd1);
    bus.flush = 1'b1;
    set_disp(6'd11, 32'h1, 32'h1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd12);
    tick();
    check("flush_cdb_out_valid", 64'(bus.cdb_out_valid), 64'd0);
    check("flush_full", 64'(bus.full), 64'd0);
    set_cdb(4'd9, 32'h77);
    tick();
    idle(5);

    // Asynchronous reset mid-run with pending and ready entries.
    for (int i = 0; i < 3; i++) begin
      set_disp(6'd12, 32'(i), 32'h0, 4'd11, 4'd0, 1'b1, 1'b0, 4'(i));
      tick();
    end
    set_disp(6'd13, 32'h8, 32'h1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5);
    tick();
    apply_reset();
    set_cdb(4'd11, 32'h99);
    tick();
    idle(5);

    // Randomized traffic with occasional freeze and flush.
    for (int n = 0; n < 600; n++) begin
      bus.rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) bus.flush = 1'b1;
      if ($urandom_range(0, 9) < 6) begin
        set_disp(6'($urandom_range(1, 63)), $urandom, $urandom,
                 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 4),
                 4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 1) == 1) set_cdb(4'($urandom_range(0, 7)), $urandom);
      tick();
    end
    bus.rdy = 1'b1;
    for (int t = 0; t < 8; t++) begin
      set_cdb(4'(t), $urandom);
      tick();
    end
    idle(25);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
